simd_fetcher: RTL and testbench
===============================

// Module: simd_fetcher
// PURPOSE
//  Per-SIMD instruction fetcher; the consumer side of the per-SIMD PC. Reads pc_in,
//  issues one program-memory read, holds the returned instruction until the decoder
//  takes it, then pulses UPDATE_PC to advance the PC. Sits between PC, program-memory
//  arbiter and decoder. One outstanding read; no branching or prefetch.
// PARAMETERS
//  PROGRAM_MEM_ADDR_WIDTH  32  program memory address width (matches PC)
//  PROGRAM_MEM_DATA_WIDTH  16  instruction word width
// PORTS
//  clk                 in   1     clock; all state changes on posedge
//  rst                 in   1     synchronous, active-high reset
//  enable              in   1     0 = freeze all state; outputs hold
//  DISPATCH_NEW_WAVE   in   1     new wave on this SIMD; abort current fetch
//  pc_in               in   AW    current PC value (PC's pc_out)
//  mem_read_valid      out  1     read request valid
//  mem_read_address    out  AW    request address
//  mem_read_ready      in   1     arbiter accepts request this cycle
//  mem_rsp_valid       in   1     one-cycle response pulse
//  mem_rsp_data        in   DW    response instruction word
//  instr_valid         out  1     instr_out/instr_pc valid for decoder
//  instr_out           out  DW    fetched instruction
//  instr_pc            out  AW    address instruction was fetched from
//  instr_ready         in   1     decoder consumes instruction this cycle
//  UPDATE_PC           out  1     one-cycle pulse: PC advances
//  busy                out  1     state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; every output 0; rst overrides enable and DISPATCH_NEW_WAVE.
//  enable=0: no state or output change; mem_rsp_valid pulses arriving then are lost.
//  States: IDLE, REQ, WAIT, HOLD, DRAIN.
//   IDLE: next cycle -> REQ, latching pc_in into mem_read_address and instr_pc.
//   REQ: mem_read_valid=1, address stable until handshake; valid&ready -> WAIT.
//   WAIT: on mem_rsp_valid latch mem_rsp_data into instr_out -> HOLD.
//     Response in the handshake cycle is illegal (memory latency >= 1).
//   HOLD: instr_valid=1; on instr_ready: instr_valid drops, UPDATE_PC pulses
//     next cycle, -> IDLE. Back-to-back fetch: 4 cycles minimum per instruction.
//  UPDATE_PC is registered, high exactly one cycle per consumed instruction.
//  DISPATCH_NEW_WAVE (priority over all else except rst):
//   IDLE/REQ -> IDLE, drop mem_read_valid; no memory traffic outstanding.
//   WAIT -> DRAIN; in DRAIN mem_rsp_valid discarded -> IDLE; no instr_valid.
//   HOLD -> IDLE; instr_valid cleared; no UPDATE_PC even if instr_ready same cycle.
//   DRAIN -> DRAIN (repeat dispatch still waits for the same response).
//  Reset during WAIT/DRAIN: response arriving in IDLE is ignored.
//  mem_rsp_valid in IDLE/REQ/HOLD: ignored. No arithmetic on PC here.
// STRUCTURE
//  Shared package: fetcher state enum (3-bit) and default widths, shared with PC and
//  decoder. Single flat module, no sub-module; state register plus address and
//  instruction latches.
// TESTING
//  Reset then pc_in=5, ready=1, rsp 2 cyc later data=16'hA123, instr_ready=1 ->
//   address=5, instr_out=A123, instr_pc=5, one UPDATE_PC pulse, back to IDLE.
//  mem_read_ready low 3 cycles -> mem_read_valid held 4 cycles, address constant.
//  Dispatch in WAIT, rsp 3 cycles later -> DRAIN, no instr_valid, no UPDATE_PC.
//  Dispatch in HOLD with instr_ready=1 same cycle -> instr_valid drops, no UPDATE_PC.
//  enable=0 for 5 cycles in HOLD -> all outputs frozen; resumes on enable=1.
//  rst asserted in REQ with enable=0 -> next cycle IDLE, all outputs 0.

Source files
------------

// File: rtl/simd_fetcher_pkg.sv
// Shared fetcher definitions: state encoding and default bus widths used by the
// PC, fetcher and decoder.
package simd_fetcher_pkg;

   localparam int unsigned PROGRAM_MEM_ADDR_WIDTH_DEF = 32;
   localparam int unsigned PROGRAM_MEM_DATA_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      FETCH_IDLE  = 3'd0,
      FETCH_REQ   = 3'd1,
      FETCH_WAIT  = 3'd2,
      FETCH_HOLD  = 3'd3,
      FETCH_DRAIN = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/simd_fetcher.sv
// Per-SIMD instruction fetcher: latches the PC, issues one program-memory read,
// holds the returned word for the decoder and pulses UPDATE_PC once it is consumed.
module simd_fetcher
   import simd_fetcher_pkg::*;
#(
   parameter int unsigned PROGRAM_MEM_ADDR_WIDTH = PROGRAM_MEM_ADDR_WIDTH_DEF,
   parameter int unsigned PROGRAM_MEM_DATA_WIDTH = PROGRAM_MEM_DATA_WIDTH_DEF
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic                              DISPATCH_NEW_WAVE,
   input  logic [PROGRAM_MEM_ADDR_WIDTH-1:0] pc_in,
   output logic                              mem_read_valid,
   output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] mem_read_address,
   input  logic                              mem_read_ready,
   input  logic                              mem_rsp_valid,
   input  logic [PROGRAM_MEM_DATA_WIDTH-1:0] mem_rsp_data,
   output logic                              instr_valid,
   output logic [PROGRAM_MEM_DATA_WIDTH-1:0] instr_out,
   output logic [PROGRAM_MEM_ADDR_WIDTH-1:0] instr_pc,
   input  logic                              instr_ready,
   output logic                              UPDATE_PC,
   output logic                              busy
);

   fetch_state_e state_q, state_d;
   logic         load_pc;
   logic         load_instr;
   logic         update_d;
   logic         update_q;

   // Next-state and latch-enable decode; a new-wave dispatch overrides normal progress.
   always_comb begin
      state_d    = state_q;
      load_pc    = 1'b0;
      load_instr = 1'b0;
      update_d   = 1'b0;
      unique case (state_q)
         FETCH_IDLE: begin
            if (!DISPATCH_NEW_WAVE) begin
               state_d = FETCH_REQ;
               load_pc = 1'b1;
            end
         end
         FETCH_REQ: begin
            if (DISPATCH_NEW_WAVE)   state_d = FETCH_IDLE;
            else if (mem_read_ready) state_d = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            // A response arriving with the dispatch already retires the read,
            // so there is nothing left to drain.
            if (DISPATCH_NEW_WAVE) begin
               state_d = mem_rsp_valid ? FETCH_IDLE : FETCH_DRAIN;
            end else if (mem_rsp_valid) begin
               state_d    = FETCH_HOLD;
               load_instr = 1'b1;
            end
         end
         FETCH_HOLD: begin
            if (DISPATCH_NEW_WAVE) begin
               state_d = FETCH_IDLE;
            end else if (instr_ready) begin
               state_d  = FETCH_IDLE;
               update_d = 1'b1;
            end
         end
         FETCH_DRAIN: begin
            if (mem_rsp_valid) state_d = FETCH_IDLE;
         end
         default: state_d = FETCH_IDLE;
      endcase
   end

   // State, address/instruction latches and the registered PC-advance pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= FETCH_IDLE;
         mem_read_address <= '0;
         instr_pc         <= '0;
         instr_out        <= '0;
         update_q         <= 1'b0;
      end else if (enable) begin
         state_q  <= state_d;
         update_q <= update_d;
         if (load_pc) begin
            mem_read_address <= pc_in;
            instr_pc         <= pc_in;
         end
         if (load_instr) instr_out <= mem_rsp_data;
      end
   end

   // Handshake flags follow directly from the registered state.
   always_comb begin
      mem_read_valid = (state_q == FETCH_REQ);
      instr_valid    = (state_q == FETCH_HOLD);
      busy           = (state_q != FETCH_IDLE);
      UPDATE_PC      = update_q;
   end

endmodule

// File: tb/tb_simd_fetcher.sv
// Bench for simd_fetcher: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural fetch model.
module tb_simd_fetcher;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        enable = 1'b0;
   logic        disp = 1'b0;
   logic [31:0] pc_in = '0;
   logic        mem_read_valid;
   logic [31:0] mem_read_address;
   logic        mem_read_ready = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [15:0] mem_rsp_data = '0;
   logic        instr_valid;
   logic [15:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        update_pc;
   logic        busy;

   int checks = 0;
   int errors = 0;

   // model: phase 0 idle, 1 requesting, 2 awaiting response, 3 holding, 4 draining
   int          m_phase = 0;
   int          m_prev  = 0;
   logic [31:0] m_addr  = '0;
   logic [31:0] m_ipc   = '0;
   logic [15:0] m_instr = '0;
   logic        m_upd   = 1'b0;

   bit pending = 0;
   int rsp_cnt = 0;

   simd_fetcher #(
      .PROGRAM_MEM_ADDR_WIDTH(32),
      .PROGRAM_MEM_DATA_WIDTH(16)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .enable            (enable),
      .DISPATCH_NEW_WAVE (disp),
      .pc_in             (pc_in),
      .mem_read_valid    (mem_read_valid),
      .mem_read_address  (mem_read_address),
      .mem_read_ready    (mem_read_ready),
      .mem_rsp_valid     (mem_rsp_valid),
      .mem_rsp_data      (mem_rsp_data),
      .instr_valid       (instr_valid),
      .instr_out         (instr_out),
      .instr_pc          (instr_pc),
      .instr_ready       (instr_ready),
      .UPDATE_PC         (update_pc),
      .busy              (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock of the fetch protocol as described: a fetch latches the PC,
   // waits for the bus, waits for the word, offers it, and reports consumption.
   task automatic model_step();
      m_prev = m_phase;
      if (rst) begin
         m_phase = 0; m_addr = '0; m_ipc = '0; m_instr = '0; m_upd = 1'b0;
      end else if (enable) begin
         m_upd = 1'b0;
         if (m_phase == 0) begin
            if (!disp) begin m_addr = pc_in; m_ipc = pc_in; m_phase = 1; end
         end else if (m_phase == 1) begin
            if (disp) m_phase = 0;
            else if (mem_read_ready) m_phase = 2;
         end else if (m_phase == 2) begin
            if (disp) m_phase = mem_rsp_valid ? 0 : 4;
            else if (mem_rsp_valid) begin m_instr = mem_rsp_data; m_phase = 3; end
         end else if (m_phase == 3) begin
            if (disp) m_phase = 0;
            else if (instr_ready) begin m_phase = 0; m_upd = 1'b1; end
         end else begin
            if (mem_rsp_valid) m_phase = 0;
         end
      end
   endtask

   task automatic compare_all();
      check_eq("mem_read_valid", 64'(mem_read_valid), 64'(m_phase == 1));
      check_eq("mem_read_address", 64'(mem_read_address), 64'(m_addr));
      check_eq("instr_valid", 64'(instr_valid), 64'(m_phase == 3));
      check_eq("instr_out", 64'(instr_out), 64'(m_instr));
      check_eq("instr_pc", 64'(instr_pc), 64'(m_ipc));
      check_eq("UPDATE_PC", 64'(update_pc), 64'(m_upd));
      check_eq("busy", 64'(busy), 64'(m_phase != 0));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic quiet();
      rst = 1'b0; enable = 1'b1; disp = 1'b0; mem_read_ready = 1'b0;
      mem_rsp_valid = 1'b0; instr_ready = 1'b0;
   endtask

   initial begin
      // basic fetch: pc 5, response two cycles after handshake
      quiet(); rst = 1'b1; tick();
      check_eq("reset_busy", 64'(busy), 64'd0);
      check_eq("reset_addr", 64'(mem_read_address), 64'd0);
      quiet(); pc_in = 32'd5; tick();
      check_eq("t1_addr", 64'(mem_read_address), 64'd5);
      mem_read_ready = 1'b1; tick();
      mem_read_ready = 1'b0; tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 16'hA123; tick();
      mem_rsp_valid = 1'b0;
      check_eq("t1_instr", 64'(instr_out), 64'hA123);
      check_eq("t1_ipc", 64'(instr_pc), 64'd5);
      instr_ready = 1'b1; tick();
      instr_ready = 1'b0;
      check_eq("t1_upd", 64'(update_pc), 64'd1);
      check_eq("t1_idle", 64'(busy), 64'd0);
      tick();
      check_eq("t1_upd_once", 64'(update_pc), 64'd0);

      // request stalled 3 cycles, address held
      pc_in = 32'd77;
      for (int unsigned i = 0; i < 3; i++) begin
         tick();
         check_eq("t2_addr_hold", 64'(mem_read_address), 64'd5);
      end
      mem_read_ready = 1'b1; tick(); mem_read_ready = 1'b0;
      check_eq("t2_handshake", 64'(mem_read_valid), 64'd0);

      // dispatch while awaiting response, then the response drains
      disp = 1'b1; tick(); disp = 1'b0;
      check_eq("t3_drain_busy", 64'(busy), 64'd1);
      tick(); tick();
      mem_rsp_valid = 1'b1; mem_rsp_data = 16'h1111; tick(); mem_rsp_valid = 1'b0;
      check_eq("t3_no_instr", 64'(instr_valid), 64'd0);
      check_eq("t3_no_upd", 64'(update_pc), 64'd0);

      // fetch to hold, freeze 5 cycles, then dispatch with instr_ready
      pc_in = 32'h40; tick();
      mem_read_ready = 1'b1; tick(); mem_read_ready = 1'b0;
      mem_rsp_valid = 1'b1; mem_rsp_data = 16'hBEEF; tick(); mem_rsp_valid = 1'b0;
      enable = 1'b0; instr_ready = 1'b1;
      for (int unsigned i = 0; i < 5; i++) begin
         tick();
         check_eq("t5_frozen_valid", 64'(instr_valid), 64'd1);
      end
      enable = 1'b1; instr_ready = 1'b0; tick();
      disp = 1'b1; instr_ready = 1'b1; tick();
      disp = 1'b0; instr_ready = 1'b0;
      check_eq("t4_valid_drop", 64'(instr_valid), 64'd0);
      tick();
      check_eq("t4_no_upd", 64'(update_pc), 64'd0);

      // reset in REQ with enable low
      check_eq("t6_in_req", 64'(mem_read_valid), 64'd1);
      enable = 1'b0; rst = 1'b1; tick();
      check_eq("t6_busy", 64'(busy), 64'd0);
      check_eq("t6_addr", 64'(mem_read_address), 64'd0);
      check_eq("t6_instr", 64'(instr_out), 64'd0);

      // randomized traffic with a well-behaved memory
      quiet(); rst = 1'b1; pending = 0; tick();
      for (int unsigned n = 0; n < 3000; n++) begin
         rst            = ($urandom_range(0, 99) < 2);
         enable         = ($urandom_range(0, 99) < 90);
         disp           = ($urandom_range(0, 99) < 5);
         pc_in          = $urandom;
         mem_read_ready = ($urandom_range(0, 99) < 60);
         instr_ready    = ($urandom_range(0, 99) < 50);
         mem_rsp_data   = 16'($urandom);
         mem_rsp_valid  = 1'b0;
         if (rst) begin
            pending = 0;
         end else if (pending) begin
            if (enable) begin
               if (rsp_cnt == 0) begin
                  mem_rsp_valid = 1'b1; pending = 0; disp = 1'b0;
               end else begin
                  rsp_cnt--;
               end
            end
         end else if (m_phase == 0 || m_phase == 1 || m_phase == 3) begin
            mem_rsp_valid = ($urandom_range(0, 99) < 10);
         end
         tick();
         if (m_phase == 2 && m_prev == 1) begin
            pending = 1;
            rsp_cnt = $urandom_range(0, 3);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
